// File: rtl/microcode_sequencer.sv
// Microstep sequencer for the 8-bit CPU: forms the microcode ROM address, gates the
// control word, generates the datapath tick, and tracks halt/resume and retired count.
// Optional feature: define EARLY_END_EN to end an instruction on an all-zero word at step>=2.
module microcode_sequencer #(
  parameter int MAX_STEP = 5,
  parameter int STEP_W   = 3,
  parameter int OPC_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [OPC_W-1:0]          opcode,
  input  logic                      flag_c,
  input  logic                      flag_z,
  input  logic [15:0]               rom_data,
  input  logic                      run_mode,
  input  logic                      step_req,
  input  logic                      resume,
  output logic [2+OPC_W+STEP_W-1:0] rom_addr,
  output logic [15:0]               ctrl_word,
  output logic                      tick,
  output logic [STEP_W-1:0]         step,
  output logic                      halted,
  output logic [15:0]               retired
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEP - 1);

  state_t              state;
  state_t              state_nxt;
  logic [STEP_W-1:0]   step_nxt;
  logic [15:0]         retired_nxt;
  logic                in_run;
  logic                early_end;

  assign in_run    = (state == ST_RUN);
  assign halted    = (state == ST_HALT);
  assign rom_addr  = {flag_c, flag_z, opcode, step};
  assign tick      = in_run & ~reset & (run_mode | step_req);
  assign ctrl_word = (in_run & ~reset) ? rom_data : 16'h0;

`ifdef EARLY_END_EN
  // An all-zero word past the fetch steps marks the end of a short instruction.
  assign early_end = (step >= STEP_W'(2)) && (rom_data == 16'h0);
`else
  assign early_end = 1'b0;
`endif

  // Next-state logic; a halt word freezes step and retired so resume restarts cleanly.
  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    retired_nxt = retired;
    case (state)
      ST_RUN: begin
        if (tick) begin
          if (rom_data[15]) begin
            state_nxt = ST_HALT;
          end else if ((step == LAST_STEP) || early_end) begin
            step_nxt    = '0;
            retired_nxt = retired + 16'd1;
          end else begin
            step_nxt = step + 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt = ST_RUN;
          step_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        step_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      step    <= '0;
      retired <= 16'h0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      retired <= retired_nxt;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: a behavioural model pushes expected outputs
// each cycle, which are popped and compared against the DUT between clock edges.
module tb_microcode_sequencer;

  localparam int MAX_STEP = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic [15:0] rom_data;
  logic        run_mode = 1'b0;
  logic        step_req = 1'b0;
  logic        resume = 1'b0;
  logic [8:0]  rom_addr;
  logic [15:0] ctrl_word;
  logic        tick;
  logic [2:0]  step;
  logic        halted;
  logic [15:0] retired;

  logic [15:0] rom_mem [0:511];

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] ctrl;
    logic        tick;
    logic [2:0]  step;
    logic        halted;
    logic [15:0] retired;
  } exp_t;

  exp_t sb[$];

  logic [2:0]  m_step;
  logic [15:0] m_retired;
  logic        m_halt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb rom_data = rom_mem[rom_addr];

  microcode_sequencer #(.MAX_STEP(MAX_STEP), .STEP_W(3), .OPC_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .rom_data(rom_data), .run_mode(run_mode), .step_req(step_req), .resume(resume),
    .rom_addr(rom_addr), .ctrl_word(ctrl_word), .tick(tick), .step(step),
    .halted(halted), .retired(retired)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, compare, then advance the model.
  task automatic applyStimulus(input logic rst, input logic rm, input logic sr, input logic rs);
    exp_t        e;
    exp_t        got;
    logic [15:0] w;
    logic        ends;
    @(negedge clk);
    reset    = rst;
    run_mode = rm;
    step_req = sr;
    resume   = rs;
    #1;
    e.addr    = {flag_c, flag_z, opcode, m_step};
    e.tick    = !m_halt && !rst && (rm || sr);
    e.ctrl    = (!m_halt && !rst) ? rom_mem[e.addr] : 16'h0;
    e.step    = m_step;
    e.halted  = m_halt;
    e.retired = m_retired;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    checkOutput("rom_addr",  16'(rom_addr),  16'(got.addr));
    checkOutput("ctrl_word", ctrl_word,      got.ctrl);
    checkOutput("tick",      16'(tick),      16'(got.tick));
    checkOutput("step",      16'(step),      16'(got.step));
    checkOutput("halted",    16'(halted),    16'(got.halted));
    checkOutput("retired",   retired,        got.retired);
    @(posedge clk);
    w = rom_mem[e.addr];
`ifdef EARLY_END_EN
    ends = (m_step == 3'(MAX_STEP - 1)) || (m_step >= 3'd2 && w == 16'h0);
`else
    ends = (m_step == 3'(MAX_STEP - 1));
`endif
    if (rst) begin
      m_step = 3'd0; m_retired = 16'h0; m_halt = 1'b0;
    end else if (m_halt) begin
      if (rs) begin m_halt = 1'b0; m_step = 3'd0; end
    end else if (e.tick) begin
      if (w[15]) m_halt = 1'b1;
      else if (ends) begin m_step = 3'd0; m_retired = m_retired + 16'd1; end
      else m_step = m_step + 3'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom_mem[i] = 16'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_step = 3'd0; m_retired = 16'h0; m_halt = 1'b0;

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_step", 16'(step), 16'h0);
    checkOutput("rst_retired", retired, 16'h0);
    checkOutput("rst_halted", 16'(halted), 16'h0);

    opcode = 4'h1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef EARLY_END_EN
    checkOutput("free_retired", retired, 16'd3);
    checkOutput("free_addr", 16'(rom_addr), 16'h009);
`else
    checkOutput("free_retired", retired, 16'd2);
    checkOutput("free_addr", 16'(rom_addr), 16'h008);
`endif

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef EARLY_END_EN
    checkOutput("manual_step", 16'(step), 16'd1);
`else
    checkOutput("manual_step", 16'(step), 16'd3);
`endif

    opcode = 4'h7; flag_c = 1'b1; flag_z = 1'b0;
    #1;
`ifdef EARLY_END_EN
    checkOutput("addr_c1", 16'(rom_addr), 16'h139);
    flag_c = 1'b0; #1;
    checkOutput("addr_c0", 16'(rom_addr), 16'h039);
`else
    checkOutput("addr_c1", 16'(rom_addr), 16'h13B);
    flag_c = 1'b0; #1;
    checkOutput("addr_c0", 16'(rom_addr), 16'h03B);
`endif

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_run_step", 16'(step), 16'h0);
    checkOutput("rst_run_retired", retired, 16'h0);

    rom_mem[9'h07A] = 16'h8000;
    opcode = 4'hF;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("halt_flag", 16'(halted), 16'h1);
    checkOutput("halt_ctrl", ctrl_word, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("halt_hold_step", 16'(step), 16'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("resume_halted", 16'(halted), 16'h0);
    checkOutput("resume_step", 16'(step), 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_halt_halted", 16'(halted), 16'h0);
    checkOutput("rst_halt_step", 16'(step), 16'h0);

`ifdef EARLY_END_EN
    opcode = 4'h1;
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ee_step2", 16'(step), 16'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ee_step0", 16'(step), 16'd0);
    checkOutput("ee_retired", retired, 16'd1);
`endif

    // Random ROM contents with occasional halt and zero words.
    for (int i = 0; i < 512; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 7) != 0) w[15] = 1'b0;
      if ($urandom_range(0, 3) == 0) w = 16'h0;
      rom_mem[i] = w;
    end
    for (int i = 0; i < 400; i++) begin
      opcode = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
